mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one write port and one read port of the synchronous scratchpad memory between two requesters: the CPU data port and the HTIF host port.
- Applies fixed CPU-priority arbitration, with a starvation guard that periodically forces an HTIF grant.
- Tracks in-flight reads in a tag pipeline and routes each read response back to its requester after a fixed latency.
- Sits between the core/HTIF logic and the memory; instruction-fetch read ports bypass it.

Parameters:
- ADDR_WIDTH, 21, byte-address width.
- DATA_WIDTH, 32, data width of both requesters and the memory ports.
- MASK_WIDTH, DATA_WIDTH/8, byte-mask width (derived, not overridable).
- READ_LATENCY, 2, cycles from the read grant cycle to the memory data becoming valid (must be ≥1).
- STARVE_LIMIT, 4, consecutive CPU wins over a pending HTIF request before HTIF is forced (must be ≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- cpu_req_valid  in  1  CPU request present.
- cpu_req_ready  out  1  CPU request granted this cycle.
- cpu_req_rw  in  1  1=write, 0=read.
- cpu_req_addr  in  ADDR_WIDTH  byte address.
- cpu_req_data  in  DATA_WIDTH  write data.
- cpu_req_mask  in  MASK_WIDTH  byte write enables.
- cpu_resp_valid  out  1  CPU read data valid.
- cpu_resp_data  out  DATA_WIDTH  CPU read data.
- htif_req_valid / htif_req_ready / htif_req_rw / htif_req_addr / htif_req_data / htif_req_mask  as the CPU ports, for HTIF.
- htif_resp_valid  out  1  HTIF read data valid.
- htif_resp_data  out  DATA_WIDTH  HTIF read data.
- mem_w_en  out  1  memory write enable.
- mem_w_addr  out  ADDR_WIDTH  memory write address.
- mem_w_data  out  DATA_WIDTH  memory write data.
- mem_w_mask  out  MASK_WIDTH  memory byte mask.
- mem_r_addr  out  ADDR_WIDTH  memory read address.
- mem_r_data  in  DATA_WIDTH  memory read data, valid READ_LATENCY cycles after the address is presented.

Behaviour:
- Grants and throughput
  - At most one grant per cycle, read or write.
  - A transfer occurs when valid && ready.
  - ready is combinational from the valids and the starve state; ready never depends on ready.
- Arbitration
  - Only CPU valid: CPU is granted.
  - Only HTIF valid: HTIF is granted.
  - Both valid: CPU wins unless starve_cnt == STARVE_LIMIT, in which case HTIF wins.
- starve_cnt
  - Increments when both are valid and CPU is granted; saturates at STARVE_LIMIT.
  - Clears on any HTIF grant.
  - Is unchanged otherwise, including when HTIF drops valid without being granted.
- Write grant
  - Same cycle, combinationally: mem_w_en=1 and mem_w_addr/data/mask taken from the winner.
  - A mask of 0 is still granted and forwarded.
  - Without a write grant: mem_w_en=0; addr/data/mask are don't-care but driven to 0.
- Read grant
  - mem_r_addr = winner address, combinationally.
  - Without a read grant, mem_r_addr holds the last granted read address (register, reset 0).
  - Push tag {valid=1, owner} into a READ_LATENCY-deep shift register; non-read cycles push {0,x}.
- Responses
  - At the pipe head, valid with owner=CPU drives cpu_resp_valid=1 and cpu_resp_data=mem_r_data; likewise for HTIF.
  - The non-owner resp_data is 0.
  - Responses are registered-free (combinational from the pipe head and mem_r_data).
  - Back-to-back reads are fully pipelined: one response per cycle.
- Ordering
  - No forwarding.
  - A write granted in cycle N is visible to any read granted in cycle ≥N+1.
  - A same-address write and read cannot be granted in the same cycle (single grant).
- Addresses: passed through unmodified; alignment is the requester's responsibility.
- Reset
  - starve_cnt=0, tag pipe cleared, held read address=0.
  - While reset is high: all ready=0, mem_w_en=0, and resp_valid=0.
  - Reads in flight at reset are dropped; no response is ever produced for them.
- Requester contract: a requester may change or drop its request while ready=0; the arbiter imposes no stability rule.

Test Plan:
- CPU write addr 0x100, data 0xDEADBEEF, mask 0xF, HTIF idle → cpu_req_ready=1 same cycle; mem_w_en=1, mem_w_addr=0x100, mem_w_mask=0xF; cpu_resp_valid stays 0.
- CPU read 0x100 in cycle N, then HTIF read 0x104 in cycle N+1 → cpu_resp_valid in N+2 with mem_r_data; htif_resp_valid in N+3; never both valid in one cycle.
- Both valid continuously, STARVE_LIMIT=4 → grant sequence CPU,CPU,CPU,CPU,HTIF,CPU,CPU,CPU,CPU,HTIF…; starve_cnt returns to 0 after each HTIF grant.
- HTIF valid blocked for 2 cycles, then HTIF drops valid → starve_cnt holds 2; when HTIF reasserts alongside CPU, HTIF is forced after 2 further CPU wins.
- HTIF write 0x200=0x11223344 in cycle N, HTIF read 0x200 in N+1 → htif_resp_data=0x11223344 at N+3.
- CPU read granted in cycle N, reset asserted in N+1 for 1 cycle → no cpu_resp_valid in N+2; ready=0 during reset; normal grants resume in the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares the scratchpad write/read port between the CPU data port and HTIF.
// CPU has priority; a starvation counter periodically forces an HTIF grant.
module mem_port_arbiter #(
    parameter  int unsigned ADDR_WIDTH   = 21,
    parameter  int unsigned DATA_WIDTH   = 32,
    parameter  int unsigned READ_LATENCY = 2,
    parameter  int unsigned STARVE_LIMIT = 4,
    localparam int unsigned MASK_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cpu_req_valid,
    output logic                  cpu_req_ready,
    input  logic                  cpu_req_rw,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    input  logic [DATA_WIDTH-1:0] cpu_req_data,
    input  logic [MASK_WIDTH-1:0] cpu_req_mask,
    output logic                  cpu_resp_valid,
    output logic [DATA_WIDTH-1:0] cpu_resp_data,

    input  logic                  htif_req_valid,
    output logic                  htif_req_ready,
    input  logic                  htif_req_rw,
    input  logic [ADDR_WIDTH-1:0] htif_req_addr,
    input  logic [DATA_WIDTH-1:0] htif_req_data,
    input  logic [MASK_WIDTH-1:0] htif_req_mask,
    output logic                  htif_resp_valid,
    output logic [DATA_WIDTH-1:0] htif_resp_data,

    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic [MASK_WIDTH-1:0] mem_w_mask,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned HEAD     = READ_LATENCY - 1;

    logic [STARVE_W-1:0]     starve_q, starve_d;
    logic [READ_LATENCY-1:0] tag_v_q, tag_v_d;
    // Tag owner bit: 1 = HTIF, 0 = CPU.
    logic [READ_LATENCY-1:0] tag_o_q, tag_o_d;
    logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;

    logic                  starve_hit;
    logic                  cpu_gnt;
    logic                  htif_gnt;
    logic                  any_gnt;
    logic                  wr_gnt;
    logic                  rd_gnt;
    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [MASK_WIDTH-1:0] sel_mask;
    logic                  head_v;

    // Arbitration and winner selection
    always_comb begin
        starve_hit = (starve_q == STARVE_W'(STARVE_LIMIT));
        cpu_gnt    = !reset && cpu_req_valid && !(htif_req_valid && starve_hit);
        htif_gnt   = !reset && htif_req_valid && !cpu_gnt;
        any_gnt    = cpu_gnt || htif_gnt;
        sel_rw     = htif_gnt ? htif_req_rw   : cpu_req_rw;
        sel_addr   = htif_gnt ? htif_req_addr : cpu_req_addr;
        sel_data   = htif_gnt ? htif_req_data : cpu_req_data;
        sel_mask   = htif_gnt ? htif_req_mask : cpu_req_mask;
        wr_gnt     = any_gnt && sel_rw;
        rd_gnt     = any_gnt && !sel_rw;
    end

    assign cpu_req_ready  = cpu_gnt;
    assign htif_req_ready = htif_gnt;

    assign mem_w_en   = wr_gnt;
    assign mem_w_addr = wr_gnt ? sel_addr : '0;
    assign mem_w_data = wr_gnt ? sel_data : '0;
    assign mem_w_mask = wr_gnt ? sel_mask : '0;
    assign mem_r_addr = rd_gnt ? sel_addr : raddr_q;

    // Next-state: starvation counter, tag shift register, held read address
    always_comb begin
        starve_d = starve_q;
        tag_v_d  = '0;
        tag_o_d  = '0;
        raddr_d  = raddr_q;

        if (htif_gnt) begin
            starve_d = '0;
        end else if (cpu_gnt && htif_req_valid && !starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
        end

        tag_v_d[0] = rd_gnt;
        tag_o_d[0] = rd_gnt && htif_gnt;
        for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            tag_v_d[i] = tag_v_q[i-1];
            tag_o_d[i] = tag_o_q[i-1];
        end

        if (rd_gnt) begin
            raddr_d = sel_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q <= '0;
            tag_v_q  <= '0;
            tag_o_q  <= '0;
            raddr_q  <= '0;
        end else begin
            starve_q <= starve_d;
            tag_v_q  <= tag_v_d;
            tag_o_q  <= tag_o_d;
            raddr_q  <= raddr_d;
        end
    end

    // Response routing from the pipe head; suppressed while reset is high
    assign head_v          = tag_v_q[HEAD] && !reset;
    assign cpu_resp_valid  = head_v && !tag_o_q[HEAD];
    assign htif_resp_valid = head_v && tag_o_q[HEAD];
    assign cpu_resp_data   = cpu_resp_valid  ? mem_r_data : '0;
    assign htif_resp_data  = htif_resp_valid ? mem_r_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural 2-cycle memory, cycle-level arbitration
// model with a response scoreboard, plus directed scenario tasks.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 21;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;
    localparam int LIMIT = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_req_valid, cpu_req_ready, cpu_req_rw;
    logic [AW-1:0] cpu_req_addr;
    logic [DW-1:0] cpu_req_data;
    logic [MW-1:0] cpu_req_mask;
    logic          cpu_resp_valid;
    logic [DW-1:0] cpu_resp_data;
    logic          htif_req_valid, htif_req_ready, htif_req_rw;
    logic [AW-1:0] htif_req_addr;
    logic [DW-1:0] htif_req_data;
    logic [MW-1:0] htif_req_mask;
    logic          htif_resp_valid;
    logic [DW-1:0] htif_resp_data;
    logic          mem_w_en;
    logic [AW-1:0] mem_w_addr;
    logic [DW-1:0] mem_w_data;
    logic [MW-1:0] mem_w_mask;
    logic [AW-1:0] mem_r_addr;
    logic [DW-1:0] mem_r_data;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(LAT), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready),
        .cpu_req_rw(cpu_req_rw), .cpu_req_addr(cpu_req_addr),
        .cpu_req_data(cpu_req_data), .cpu_req_mask(cpu_req_mask),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_data(cpu_resp_data),
        .htif_req_valid(htif_req_valid), .htif_req_ready(htif_req_ready),
        .htif_req_rw(htif_req_rw), .htif_req_addr(htif_req_addr),
        .htif_req_data(htif_req_data), .htif_req_mask(htif_req_mask),
        .htif_resp_valid(htif_resp_valid), .htif_resp_data(htif_resp_data),
        .mem_w_en(mem_w_en), .mem_w_addr(mem_w_addr), .mem_w_data(mem_w_data),
        .mem_w_mask(mem_w_mask), .mem_r_addr(mem_r_addr), .mem_r_data(mem_r_data)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA500_0000 | 32'(i);
    endfunction

    // Behavioural scratchpad: 256 words, data valid two cycles after the address
    logic [31:0] mem [0:255];
    logic [31:0] rd_d1, rd_d2;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_w_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_w_mask[b]) mem[mem_w_addr[9:2]][b*8 +: 8] <= mem_w_data[b*8 +: 8];
        end
        rd_d1 <= mem[mem_r_addr[9:2]];
        rd_d2 <= rd_d1;
    end
    assign mem_r_data = rd_d2;

    typedef struct {
        int          due;
        logic        owner;
        logic [31:0] data;
    } sb_t;
    sb_t sb [$];

    logic [31:0] ref_mem [0:255];
    int          starve_m;
    logic [AW-1:0] held_m;
    logic        ec, eh, m_rw;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [MW-1:0] m_mask;
    logic        e_cv, e_hv;
    logic [DW-1:0] e_cd, e_hd;
    sb_t         ent;

    // Cycle model: expected grants, port values and routed responses
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            total++;
            if (cpu_req_ready !== 1'b0 || htif_req_ready !== 1'b0 || mem_w_en !== 1'b0 ||
                cpu_resp_valid !== 1'b0 || htif_resp_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_outputs cyc=%0d ready=%b%b w_en=%b resp=%b%b required all 0",
                         cyc, cpu_req_ready, htif_req_ready, mem_w_en, cpu_resp_valid, htif_resp_valid);
            end
            sb.delete();
            starve_m = 0;
            held_m   = '0;
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
        end else begin
            ec = cpu_req_valid && !(htif_req_valid && starve_m == LIMIT);
            eh = htif_req_valid && !ec;
            total++;
            if (cpu_req_ready !== ec || htif_req_ready !== eh) begin
                bad++;
                $display("FAIL grant cyc=%0d got cpu=%b htif=%b required cpu=%b htif=%b",
                         cyc, cpu_req_ready, htif_req_ready, ec, eh);
            end

            e_cv = 1'b0; e_hv = 1'b0; e_cd = '0; e_hd = '0;
            if (sb.size() != 0 && sb[0].due == cyc) begin
                ent = sb.pop_front();
                if (ent.owner) begin e_hv = 1'b1; e_hd = ent.data; end
                else           begin e_cv = 1'b1; e_cd = ent.data; end
            end
            total++;
            if (cpu_resp_valid !== e_cv || cpu_resp_data !== e_cd ||
                htif_resp_valid !== e_hv || htif_resp_data !== e_hd) begin
                bad++;
                $display("FAIL resp cyc=%0d got cpu=%b/%h htif=%b/%h required cpu=%b/%h htif=%b/%h",
                         cyc, cpu_resp_valid, cpu_resp_data, htif_resp_valid, htif_resp_data,
                         e_cv, e_cd, e_hv, e_hd);
            end

            if (ec || eh) begin
                m_rw   = eh ? htif_req_rw   : cpu_req_rw;
                m_addr = eh ? htif_req_addr : cpu_req_addr;
                m_data = eh ? htif_req_data : cpu_req_data;
                m_mask = eh ? htif_req_mask : cpu_req_mask;
                total++;
                if (m_rw) begin
                    if (mem_w_en !== 1'b1 || mem_w_addr !== m_addr || mem_w_data !== m_data ||
                        mem_w_mask !== m_mask || mem_r_addr !== held_m) begin
                        bad++;
                        $display("FAIL write_port cyc=%0d got en=%b a=%h d=%h m=%h ra=%h required en=1 a=%h d=%h m=%h ra=%h",
                                 cyc, mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_addr,
                                 m_addr, m_data, m_mask, held_m);
                    end
                    for (int b = 0; b < 4; b++)
                        if (m_mask[b]) ref_mem[m_addr[9:2]][b*8 +: 8] = m_data[b*8 +: 8];
                end else begin
                    if (mem_w_en !== 1'b0 || mem_r_addr !== m_addr) begin
                        bad++;
                        $display("FAIL read_port cyc=%0d got en=%b ra=%h required en=0 ra=%h",
                                 cyc, mem_w_en, mem_r_addr, m_addr);
                    end
                    sb.push_back('{cyc + LAT, eh, ref_mem[m_addr[9:2]]});
                    held_m = m_addr;
                end
            end else begin
                total++;
                if (mem_w_en !== 1'b0 || mem_w_addr !== '0 || mem_w_data !== '0 ||
                    mem_w_mask !== '0 || mem_r_addr !== held_m) begin
                    bad++;
                    $display("FAIL idle_port cyc=%0d got en=%b a=%h d=%h m=%h ra=%h required zeros ra=%h",
                             cyc, mem_w_en, mem_w_addr, mem_w_data, mem_w_mask, mem_r_addr, held_m);
                end
            end

            if (eh) starve_m = 0;
            else if (ec && htif_req_valid && starve_m < LIMIT) starve_m++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(logic v, logic rw, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        cpu_req_valid = v; cpu_req_rw = rw; cpu_req_addr = a; cpu_req_data = d; cpu_req_mask = m;
    endtask

    task automatic set_htif(logic v, logic rw, logic [AW-1:0] a, logic [DW-1:0] d, logic [MW-1:0] m);
        htif_req_valid = v; htif_req_rw = rw; htif_req_addr = a; htif_req_data = d; htif_req_mask = m;
    endtask

    task automatic idle();
        set_cpu(1'b0, 1'b0, '0, '0, '0);
        set_htif(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        set_cpu(1'b1, 1'b0, 21'h40, '0, 4'hF);
        set_htif(1'b1, 1'b1, 21'h80, 32'h1, 4'hF);
        repeat (2) begin
            @(negedge clk);
            total++;
            if (cpu_req_ready !== 1'b0 || htif_req_ready !== 1'b0 || mem_w_en !== 1'b0) begin
                bad++;
                $display("FAIL test_reset got ready=%b%b w_en=%b required 000",
                         cpu_req_ready, htif_req_ready, mem_w_en);
            end
        end
        tick();
        reset = 1'b0;
        idle();
    endtask

    task automatic test_cpu_write();
        tick();
        set_cpu(1'b1, 1'b1, 21'h100, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        total++;
        if (cpu_req_ready !== 1'b1 || mem_w_en !== 1'b1 || mem_w_addr !== 21'h100 ||
            mem_w_mask !== 4'hF || mem_w_data !== 32'hDEADBEEF || cpu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL cpu_write got rdy=%b en=%b a=%h m=%h d=%h rv=%b required 1 1 100 f deadbeef 0",
                     cpu_req_ready, mem_w_en, mem_w_addr, mem_w_mask, mem_w_data, cpu_resp_valid);
        end
        tick();
        idle();
    endtask

    task automatic test_read_pipe();
        set_cpu(1'b1, 1'b0, 21'h100, '0, '0);
        @(negedge clk);
        total++;
        if (cpu_req_ready !== 1'b1 || mem_r_addr !== 21'h100) begin
            bad++;
            $display("FAIL read_pipe_grant got rdy=%b ra=%h required 1 100", cpu_req_ready, mem_r_addr);
        end
        tick();
        set_cpu(1'b0, 1'b0, '0, '0, '0);
        set_htif(1'b1, 1'b0, 21'h104, '0, '0);
        tick();
        idle();
        @(negedge clk);
        total++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== 32'hDEADBEEF || htif_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_pipe_cpu got v=%b d=%h hv=%b required 1 deadbeef 0",
                     cpu_resp_valid, cpu_resp_data, htif_resp_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (htif_resp_valid !== 1'b1 || htif_resp_data !== init_word(32'h41) || cpu_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL read_pipe_htif got v=%b d=%h cv=%b required 1 %h 0",
                     htif_resp_valid, htif_resp_data, cpu_resp_valid, init_word(32'h41));
        end
    endtask

    task automatic test_starve();
        logic exp_h;
        tick();
        set_cpu(1'b1, 1'b0, 21'h10, '0, '0);
        set_htif(1'b1, 1'b0, 21'h20, '0, '0);
        for (int i = 0; i < 10; i++) begin
            exp_h = (i == 4) || (i == 9);
            @(negedge clk);
            total++;
            if (htif_req_ready !== exp_h || cpu_req_ready !== !exp_h) begin
                bad++;
                $display("FAIL starve_seq step=%0d got cpu=%b htif=%b required htif=%b",
                         i, cpu_req_ready, htif_req_ready, exp_h);
            end
            tick();
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_starve_hold();
        bit [7:0] hv_tab  = 8'b1110_0011;
        bit [7:0] exp_tab = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            set_cpu(1'b1, 1'b0, 21'h30, '0, '0);
            set_htif(hv_tab[i], 1'b0, 21'h34, '0, '0);
            @(negedge clk);
            total++;
            if (htif_req_ready !== exp_tab[i] || cpu_req_ready !== !exp_tab[i]) begin
                bad++;
                $display("FAIL starve_hold step=%0d got cpu=%b htif=%b required htif=%b",
                         i, cpu_req_ready, htif_req_ready, exp_tab[i]);
            end
            tick();
        end
        idle();
        repeat (3) tick();
    endtask

    task automatic test_htif_wr_rd();
        set_htif(1'b1, 1'b1, 21'h200, 32'h11223344, 4'hF);
        @(negedge clk);
        total++;
        if (htif_req_ready !== 1'b1 || mem_w_en !== 1'b1 || mem_w_addr !== 21'h200) begin
            bad++;
            $display("FAIL htif_write got rdy=%b en=%b a=%h required 1 1 200",
                     htif_req_ready, mem_w_en, mem_w_addr);
        end
        tick();
        set_htif(1'b1, 1'b0, 21'h200, '0, '0);
        tick();
        idle();
        @(negedge clk);
        total++;
        if (htif_resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL htif_early got v=%b required 0", htif_resp_valid);
        end
        tick();
        @(negedge clk);
        total++;
        if (htif_resp_valid !== 1'b1 || htif_resp_data !== 32'h11223344) begin
            bad++;
            $display("FAIL htif_readback got v=%b d=%h required 1 11223344",
                     htif_resp_valid, htif_resp_data);
        end
        tick();
    endtask

    task automatic test_mask0();
        set_cpu(1'b1, 1'b1, 21'h300, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        total++;
        if (cpu_req_ready !== 1'b1 || mem_w_en !== 1'b1 || mem_w_mask !== 4'h0 || mem_w_addr !== 21'h300) begin
            bad++;
            $display("FAIL mask0_write got rdy=%b en=%b m=%h a=%h required 1 1 0 300",
                     cpu_req_ready, mem_w_en, mem_w_mask, mem_w_addr);
        end
        tick();
        set_cpu(1'b1, 1'b0, 21'h300, '0, '0);
        tick();
        idle();
        tick();
        @(negedge clk);
        total++;
        if (cpu_resp_valid !== 1'b1 || cpu_resp_data !== init_word(32'hC0)) begin
            bad++;
            $display("FAIL mask0_readback got v=%b d=%h required 1 %h",
                     cpu_resp_valid, cpu_resp_data, init_word(32'hC0));
        end
        tick();
    endtask

    task automatic test_inflight_reset();
        set_cpu(1'b1, 1'b0, 21'h104, '0, '0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (cpu_req_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready got %b required 0", cpu_req_ready);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cpu_resp_valid !== 1'b0 || cpu_req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_drop got rv=%b rdy=%b required 0 1", cpu_resp_valid, cpu_req_ready);
        end
        tick();
        idle();
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_cpu(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, 255) * 4), $urandom, 4'($urandom_range(0, 15)));
            set_htif(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     AW'($urandom_range(0, 255) * 4), $urandom, 4'($urandom_range(0, 15)));
            tick();
        end
        idle();
        repeat (4) tick();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d required 0", sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_cpu_write();
        test_read_pipe();
        test_starve();
        test_starve_hold();
        test_htif_wr_rd();
        test_mask0();
        test_inflight_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
